mvu_pe_xnor_seq: RTL and testbench
==================================

# mvu_pe_xnor_seq

Sequencer and accumulator for one binary (1-bit weight, 1-bit activation) processing element of the Matrix-Vector-Multiplication Unit. It accepts a stream of SIMD-wide activation/weight beats over a valid/ready handshake and forms the per-lane XNOR products in a registered stage. It accumulates their popcount over SF beats (one synapse fold) and presents the dot-product result on a valid/ready output. It sits between the MVU input/weight buffers and the PE output/threshold stage.

## Interface
- SIMD, default 4: lanes per beat (activation and weight bits per beat), ≥1.
- SF, default 8: beats per output (synapse fold), ≥1.
- TO, default 16: output/accumulator width; must satisfy TO ≥ clog2(SIMD*SF+1).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_v  input  1  input beat valid.
- in_rdy  output  1  input beat ready.
- in_act  input  SIMD  binary activations, one bit per lane.
- in_wgt  input  SIMD  binary weights, one bit per lane.
- out_v  output  1  result valid.
- out_rdy  input  1  downstream ready.
- out  output  TO  dot-product result: count of matching lanes over SF beats.
- busy  output  1  high while any beat of an incomplete fold is held internally (beat_cnt≠0 or s1_v).

## Operation
- Accept: beat taken when in_v && in_rdy.
- hold = out_v && !out_rdy. in_rdy = !hold (combinational). No combinational path from in_v to in_rdy.
- Stage 1 (XNOR): on accept, s1_x <= in_act ~^ in_wgt, s1_v <= 1, s1_last <= (beat_cnt == SF-1). If no accept and !hold, s1_v <= 0. If hold, s1_* frozen.
- beat_cnt: 0..SF-1. Increments on accept and wraps SF-1 -> 0. With SF=1 it stays 0 and every beat is last.
- Stage 2 (accumulate), when s1_v && !hold:
  - sum = acc + popcount(s1_x), computed at TO bits with no overflow given the TO constraint.
  - s1_last=0: acc <= sum.
  - s1_last=1: out <= sum, out_v <= 1, acc <= 0.
- Output handshake:
  - out_v && out_rdy with no new last retiring: out_v <= 0, and out holds its last value.
  - Same cycle as a last retiring: out reloads and out_v stays 1, giving back-to-back results.
- While hold: accumulator, stage 1, beat_cnt and out are all frozen, and in_rdy=0. out must stay stable until accepted.
- Control states:
  - ACC (out_v=0).
  - FULL (out_v=1).
  - Transitions:
    - ACC→FULL on last retiring.
    - FULL→ACC on out_rdy with no last retiring.
    - FULL→FULL on out_rdy with a last retiring, or on !out_rdy.

## Timing
- Reset values: out_v=0, out=0, in_rdy=1 (since out_v=0), busy=0. acc, beat_cnt, s1_v and s1_last are 0.
- Reset mid-fold discards the partial accumulation and any pending result. The next accepted beat is beat 0.
- Latency: last beat accepted on edge t; s1 loaded at t; out_v=1 and out valid after edge t+1 (2 cycles from acceptance to output).
- Throughput: 1 beat/cycle sustained while out_rdy=1. One result per SF cycles, with no bubble between folds.
- Backpressure: out_rdy low while out_v=1 stalls the whole pipeline in the same cycle via in_rdy=0. No beat is lost or duplicated.
- in_v may drop between beats. Gaps only delay the result, and the partial accumulation is preserved.

## Test plan
- Single fold, SIMD=4, SF=2, out_rdy=1:
  - Stimulus: beats (act=1111, wgt=1111), then (act=1010, wgt=0110).
  - Required: out_v pulses 1 cycle, 2 cycles after the second accept, with out=4+2=6. busy returns to 0.
- Back-to-back folds, SF=2, continuous in_v:
  - Stimulus: 4 beats with all lanes matching, then 4 beats with none matching.
  - Required: results 8, 8, 0, 0. out_v high on consecutive fold boundaries and in_rdy constantly 1.
- Backpressure, SF=2:
  - Stimulus: out_rdy=0 when the first result 8 appears; hold 5 cycles with in_v=1.
  - Required:
    - out=8 stable and in_rdy=0 during the hold.
    - After out_rdy=1, the next fold completes correctly.
    - The total result count equals the folds sent.
- Gapped input, SF=3, SIMD=4:
  - Stimulus: beats with popcounts 3, 1, 4, with 2 idle cycles between each.
  - Required: a single result out=8, 2 cycles after the third accept.
- Reset mid-fold, SF=4:
  - Stimulus: assert rst after 2 beats, asynchronously between edges.
  - Required:
    - out_v=0, out=0 and busy=0 immediately.
    - Then 4 fresh beats of all-ones give out=16.
- SF=1, SIMD=1:
  - Stimulus: alternating match/mismatch beats.
  - Required: one result per beat, values 1, 0, 1, 0 at 2-cycle latency each.

Source files
------------

// File: rtl/mvu_pe_xnor_seq_if.sv
// Beat-in / result-out handshake bundle for one binary MVU processing element.
// master drives beats and result ready; slave is the processing element.
interface mvu_pe_xnor_seq_if #(
    parameter int SIMD = 4,
    parameter int TO   = 16
);
    logic            in_v;
    logic            in_rdy;
    logic [SIMD-1:0] in_act;
    logic [SIMD-1:0] in_wgt;
    logic            out_v;
    logic            out_rdy;
    logic [TO-1:0]   out;
    logic            busy;

    modport master (
        output in_v, in_act, in_wgt, out_rdy,
        input  in_rdy, out_v, out, busy
    );

    modport slave (
        input  in_v, in_act, in_wgt, out_rdy,
        output in_rdy, out_v, out, busy
    );
endinterface

// File: rtl/mvu_pe_xnor_seq.sv
// Binary PE: XNOR each SIMD beat, accumulate popcount over SF beats, emit one dot product per fold.
// Latency 2 cycles from last-beat accept to out_v; a held result (out_v && !out_rdy) freezes the whole pipe.
module mvu_pe_xnor_seq #(
    parameter int SIMD = 4,
    parameter int SF   = 8,
    parameter int TO   = 16
) (
    input  logic               clk,
    input  logic               rst,
    mvu_pe_xnor_seq_if.slave   io
);
    localparam int            CW        = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(SF - 1);

    typedef enum logic {ACC, FULL} state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   beat_cnt;
    logic [SIMD-1:0] s1_x;
    logic            s1_v;
    logic            s1_last;
    logic [TO-1:0]   acc;
    logic [TO-1:0]   out_q;
    logic [TO-1:0]   sum;

    logic            out_v;
    logic            hold;
    logic            accept;
    logic            retire;
    logic            last_ret;

    function automatic logic [TO-1:0] popcount(input logic [SIMD-1:0] x);
        logic [TO-1:0] c;
        c = '0;
        for (int i = 0; i < SIMD; i++) begin
            c = c + TO'(x[i]);
        end
        return c;
    endfunction

    assign out_v    = (state == FULL);
    assign hold     = out_v && !io.out_rdy;
    assign accept   = io.in_v && !hold;
    assign retire   = s1_v && !hold;
    assign last_ret = retire && s1_last;
    assign sum      = acc + popcount(s1_x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // A last retiring while the previous result is handed off keeps FULL, giving back-to-back folds.
    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (last_ret) state_next = FULL;
            FULL:    if (!hold && !last_ret) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            s1_x     <= '0;
            s1_v     <= 1'b0;
            s1_last  <= 1'b0;
            acc      <= '0;
            out_q    <= '0;
        end else begin
            if (accept) begin
                s1_x     <= io.in_act ~^ io.in_wgt;
                s1_v     <= 1'b1;
                s1_last  <= (beat_cnt == LAST_BEAT);
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end else if (!hold) begin
                s1_v <= 1'b0;
            end

            if (retire) begin
                if (s1_last) begin
                    out_q <= sum;
                    acc   <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    assign io.in_rdy = !hold;
    assign io.out_v  = out_v;
    assign io.out    = out_q;
    assign io.busy   = (beat_cnt != '0) || s1_v;
endmodule

// File: tb/tb_mvu_pe_xnor_seq.sv
// Drives four PE configurations; the SF=2 instance is also checked against a fold-level popcount model.
module tb_mvu_pe_xnor_seq;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mvu_pe_xnor_seq_if #(.SIMD(4), .TO(16)) ia ();
    mvu_pe_xnor_seq_if #(.SIMD(4), .TO(16)) ib ();
    mvu_pe_xnor_seq_if #(.SIMD(4), .TO(16)) ic ();
    mvu_pe_xnor_seq_if #(.SIMD(1), .TO(4))  id ();

    mvu_pe_xnor_seq #(.SIMD(4), .SF(2), .TO(16)) ua (.clk(clk), .rst(rst), .io(ia));
    mvu_pe_xnor_seq #(.SIMD(4), .SF(3), .TO(16)) ub (.clk(clk), .rst(rst), .io(ib));
    mvu_pe_xnor_seq #(.SIMD(4), .SF(4), .TO(16)) uc (.clk(clk), .rst(rst), .io(ic));
    mvu_pe_xnor_seq #(.SIMD(1), .SF(1), .TO(4))  ud (.clk(clk), .rst(rst), .io(id));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for instance ia: each accepted beat adds its matching-lane count; every 2nd beat closes a fold.
    int exp_q[$];
    int got_q[$];
    int m_acc = 0;
    int m_n   = 0;
    int n_acc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            m_acc = 0;
            m_n   = 0;
        end else begin
            if (ia.in_v && ia.in_rdy) begin
                m_acc = m_acc + $countones(~(ia.in_act ^ ia.in_wgt));
                m_n   = m_n + 1;
                n_acc = n_acc + 1;
                if (m_n == 2) begin
                    exp_q.push_back(m_acc);
                    m_acc = 0;
                    m_n   = 0;
                end
            end
            if (ia.out_v && ia.out_rdy) got_q.push_back(int'(ia.out));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        ia.in_v = 1'b0; ia.in_act = '0; ia.in_wgt = '0; ia.out_rdy = 1'b1;
        ib.in_v = 1'b0; ib.in_act = '0; ib.in_wgt = '0; ib.out_rdy = 1'b1;
        ic.in_v = 1'b0; ic.in_act = '0; ic.in_wgt = '0; ic.out_rdy = 1'b1;
        id.in_v = 1'b0; id.in_act = '0; id.in_wgt = '0; id.out_rdy = 1'b1;
    endtask

    task automatic clear_model;
        exp_q.delete();
        got_q.delete();
        n_acc = 0;
    endtask

    task automatic test_reset;
        idle_all();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        total++; if (ia.out_v !== 1'b0) begin bad++; $display("FAIL reset_out_v got=%0b want=0", ia.out_v); end
        total++; if (ia.out !== 16'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", ia.out); end
        total++; if (ia.in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%0b want=1", ia.in_rdy); end
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", ia.busy); end
        total++; if (id.out_v !== 1'b0 || id.out !== 4'd0) begin bad++; $display("FAIL reset_sf1 got=%0b/%0d want=0/0", id.out_v, id.out); end
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fold;
        clear_model();
        ia.out_rdy = 1'b1;
        ia.in_v = 1'b1; ia.in_act = 4'b1111; ia.in_wgt = 4'b1111;
        tick();
        total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL single_busy_mid got=%0b want=1", ia.busy); end
        ia.in_act = 4'b1010; ia.in_wgt = 4'b0110;
        tick();
        ia.in_v = 1'b0;
        total++; if (ia.out_v !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", ia.out_v); end
        tick();
        total++; if (ia.out_v !== 1'b1 || ia.out !== 16'd6) begin bad++; $display("FAIL single_result got=%0b/%0d want=1/6", ia.out_v, ia.out); end
        tick();
        total++; if (ia.out_v !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b want=0", ia.out_v); end
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%0b want=0", ia.busy); end
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] != exp_q[0]) begin
            bad++; $display("FAIL single_model got_n=%0d exp_n=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int res[$];
        int at[$];
        int want[4] = '{8, 8, 0, 0};
        clear_model();
        ia.out_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                ia.in_v   = 1'b1;
                ia.in_act = 4'($urandom);
                ia.in_wgt = (k < 4) ? ia.in_act : ~ia.in_act;
            end else begin
                ia.in_v = 1'b0;
            end
            #1;
            if (k < 8) begin
                total++; if (ia.in_rdy !== 1'b1) begin bad++; $display("FAIL b2b_in_rdy k=%0d got=%0b want=1", k, ia.in_rdy); end
            end
            tick();
            if (ia.out_v) begin
                res.push_back(int'(ia.out));
                at.push_back(k);
            end
        end
        total++; if (res.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", res.size()); end
        for (int i = 0; i < 4 && i < res.size(); i++) begin
            total++; if (res[i] != want[i]) begin bad++; $display("FAIL b2b_value i=%0d got=%0d want=%0d", i, res[i], want[i]); end
            total++; if (at[i] != 2 + 2 * i) begin bad++; $display("FAIL b2b_timing i=%0d got=%0d want=%0d", i, at[i], 2 + 2 * i); end
        end
    endtask

    task automatic test_backpressure;
        bit held = 1'b0;
        int n_before;
        clear_model();
        ia.out_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            ia.in_v   = (n_acc < 6);
            ia.in_act = 4'($urandom);
            ia.in_wgt = ia.in_act;
            if (!held && ia.out_v) begin
                held = 1'b1;
                ia.out_rdy = 1'b0;
                n_before = n_acc;
                for (int h = 0; h < 5; h++) begin
                    #1;
                    total++; if (ia.in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy h=%0d got=%0b want=0", h, ia.in_rdy); end
                    total++; if (ia.out_v !== 1'b1 || ia.out !== 16'd8) begin bad++; $display("FAIL bp_stable h=%0d got=%0b/%0d want=1/8", h, ia.out_v, ia.out); end
                    tick();
                end
                total++; if (n_acc != n_before) begin bad++; $display("FAIL bp_no_accept got=%0d want=%0d", n_acc, n_before); end
                ia.out_rdy = 1'b1;
            end
            tick();
        end
        total++; if (!held) begin bad++; $display("FAIL bp_no_result got=0 want=1"); end
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] != 8) begin bad++; $display("FAIL bp_value i=%0d got=%0d want=8", i, got_q[i]); end
        end
    endtask

    task automatic test_gapped;
        logic [3:0] masks[3] = '{4'b1110, 4'b0100, 4'b1111};
        ib.out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ib.in_v   = 1'b1;
            ib.in_act = 4'($urandom);
            ib.in_wgt = ib.in_act ^ ~masks[k];
            tick();
            ib.in_v = 1'b0;
            if (k < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    total++; if (ib.out_v !== 1'b0 || ib.busy !== 1'b1) begin bad++; $display("FAIL gap_idle k=%0d got=%0b/%0b want=0/1", k, ib.out_v, ib.busy); end
                end
            end
        end
        total++; if (ib.out_v !== 1'b0) begin bad++; $display("FAIL gap_early got=%0b want=0", ib.out_v); end
        tick();
        total++; if (ib.out_v !== 1'b1 || ib.out !== 16'd8) begin bad++; $display("FAIL gap_result got=%0b/%0d want=1/8", ib.out_v, ib.out); end
        tick();
        total++; if (ib.out_v !== 1'b0 || ib.busy !== 1'b0) begin bad++; $display("FAIL gap_end got=%0b/%0b want=0/0", ib.out_v, ib.busy); end
    endtask

    task automatic test_reset_mid_fold;
        ic.out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ic.in_v   = 1'b1;
            ic.in_act = 4'($urandom);
            ic.in_wgt = ic.in_act ^ 4'b0001;
            tick();
        end
        ic.in_v = 1'b0;
        tick(); tick();
        total++; if (ic.out !== 16'd12) begin bad++; $display("FAIL rmf_pre_out got=%0d want=12", ic.out); end
        for (int k = 0; k < 2; k++) begin
            ic.in_v   = 1'b1;
            ic.in_act = 4'($urandom);
            ic.in_wgt = ic.in_act;
            tick();
        end
        ic.in_v = 1'b0;
        total++; if (ic.busy !== 1'b1) begin bad++; $display("FAIL rmf_pre_busy got=%0b want=1", ic.busy); end
        #3 rst = 1'b0;
        #1;
        total++; if (ic.out_v !== 1'b0 || ic.out !== 16'd0 || ic.busy !== 1'b0) begin
            bad++; $display("FAIL rmf_async got=%0b/%0d/%0b want=0/0/0", ic.out_v, ic.out, ic.busy);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            ic.in_v   = 1'b1;
            ic.in_act = 4'($urandom);
            ic.in_wgt = ic.in_act;
            tick();
            if (k < 3) begin
                total++; if (ic.out_v !== 1'b0) begin bad++; $display("FAIL rmf_short_fold k=%0d got=%0b want=0", k, ic.out_v); end
            end
        end
        ic.in_v = 1'b0;
        tick();
        total++; if (ic.out_v !== 1'b1 || ic.out !== 16'd16) begin bad++; $display("FAIL rmf_result got=%0b/%0d want=1/16", ic.out_v, ic.out); end
        tick();
    endtask

    task automatic test_sf1;
        logic want[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        id.out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                id.in_v   = 1'b1;
                id.in_act = 1'($urandom);
                id.in_wgt = want[k] ? id.in_act : ~id.in_act;
            end else begin
                id.in_v = 1'b0;
            end
            tick();
            if (k == 0) begin
                total++; if (id.out_v !== 1'b0) begin bad++; $display("FAIL sf1_early got=%0b want=0", id.out_v); end
            end else if (k <= 4) begin
                total++; if (id.out_v !== 1'b1 || id.out !== 4'(want[k-1])) begin
                    bad++; $display("FAIL sf1_result k=%0d got=%0b/%0d want=1/%0d", k - 1, id.out_v, id.out, want[k-1]);
                end
            end else begin
                total++; if (id.out_v !== 1'b0) begin bad++; $display("FAIL sf1_end got=%0b want=0", id.out_v); end
            end
        end
    endtask

    task automatic test_random;
        bit          prev_hold;
        logic [15:0] prev_out;
        clear_model();
        for (int c = 0; c < 400; c++) begin
            ia.in_v    = ($urandom_range(3) != 0);
            ia.in_act  = 4'($urandom);
            ia.in_wgt  = 4'($urandom);
            ia.out_rdy = ($urandom_range(2) != 0);
            #1;
            prev_hold = ia.out_v && !ia.out_rdy;
            prev_out  = ia.out;
            total++; if (ia.in_rdy !== !prev_hold) begin bad++; $display("FAIL rnd_in_rdy c=%0d got=%0b want=%0b", c, ia.in_rdy, !prev_hold); end
            tick();
            if (prev_hold) begin
                total++; if (ia.out_v !== 1'b1 || ia.out !== prev_out) begin
                    bad++; $display("FAIL rnd_hold c=%0d got=%0b/%0d want=1/%0d", c, ia.out_v, ia.out, prev_out);
                end
            end
        end
        ia.in_v = 1'b0;
        ia.out_rdy = 1'b1;
        repeat (6) tick();
        total++; if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
            bad++; $display("FAIL rnd_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] != exp_q[i]) begin bad++; $display("FAIL rnd_value i=%0d got=%0d want=%0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_fold();
        repeat (2) tick();
        test_back_to_back();
        repeat (2) tick();
        test_backpressure();
        repeat (2) tick();
        test_gapped();
        repeat (2) tick();
        test_reset_mid_fold();
        repeat (2) tick();
        test_sf1();
        repeat (2) tick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
